// File: rtl/channel_pkg.sv
// Shared helpers for the channel merge blocks.
// Index-width sizing used by the arbiter and its wrapper.
package channel_pkg;

  typedef int unsigned width_t;

  // Index width for n items, never below one bit
  function automatic width_t clog2_min1(input width_t n);
    return (n > 1) ? width_t'($clog2(n)) : width_t'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req at or after ptr,
// wrapping explicitly at NIN-1.
module rr_pick
  import channel_pkg::*;
#(
  parameter int NIN = 4,
  localparam int TW = clog2_min1(NIN)
) (
  input  logic [NIN-1:0] req,
  input  logic [TW-1:0]  ptr,
  output logic [TW-1:0]  gnt_idx,
  output logic           any
);

  int idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < NIN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NIN) idx = idx - NIN;
      if (!any && req[idx[TW-1:0]]) begin
        any     = 1'b1;
        gnt_idx = idx[TW-1:0];
      end
    end
  end

endmodule

// File: rtl/channel_merge_rr.sv
// N-input round-robin merge into one registered output channel,
// with optional source tag and burst lock.
module channel_merge_rr
  import channel_pkg::*;
#(
  parameter int NIN   = 4,
  parameter int W     = 32,
  parameter int TAG   = 1,
  parameter int BURST = 1,
  localparam int TW = clog2_min1(NIN),
  localparam int OW = W + TAG * TW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NIN-1:0] in_v,
  output logic [NIN-1:0] in_a,
  input  logic [NIN*W-1:0] in_d,
  output logic           out_v,
  input  logic           out_a,
  output logic [OW-1:0]  out_d
);

  localparam int BW = $clog2(BURST) + 1;
  localparam logic [TW-1:0] LAST_IDX = TW'(NIN - 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST - 1);

  logic [TW-1:0] last;
  logic [TW-1:0] ptr;
  logic [TW-1:0] pick;
  logic [TW-1:0] sel;
  logic [BW-1:0] bcnt;
  logic          any;
  logic          lock;
  logic          load;
  logic          ov;
  logic [OW-1:0] od;
  logic [OW-1:0] nxt;
  logic [W-1:0]  pay;

  assign ptr = (last == LAST_IDX) ? '0 : last + TW'(1);

  rr_pick #(.NIN(NIN)) u_pick (
    .req     (in_v),
    .ptr     (ptr),
    .gnt_idx (pick),
    .any     (any)
  );

  // Lock keeps the current input while it stays valid
  assign lock = (BURST > 1) && in_v[last] && (bcnt < BMAX);
  assign sel  = lock ? last : pick;
  assign load = !reset && any && (!ov || out_a);
  assign in_a = load ? (NIN'(1) << sel) : '0;
  assign pay  = in_d[int'(sel)*W +: W];

  if (TAG != 0) begin : g_tag
    assign nxt = {sel, pay};
  end else begin : g_raw
    assign nxt = pay;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov   <= 1'b0;
      od   <= '0;
      last <= LAST_IDX;
      bcnt <= '0;
    end else if (load) begin
      ov   <= 1'b1;
      od   <= nxt;
      last <= sel;
      // Sole requester past its burst holds the count at the cap
      if (sel != last)
        bcnt <= '0;
      else if (bcnt < BMAX)
        bcnt <= bcnt + BW'(1);
    end else if (out_a) begin
      ov <= 1'b0;
    end
  end

  assign out_v = ov;
  assign out_d = od;

endmodule

// File: tb/tb_channel_merge_rr.sv
// Bench for channel_merge_rr: directed arbitration checks on three
// configurations plus a scoreboarded random run on the burst variant.
module tb_channel_merge_rr;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0]     a_v, a_a;
  logic [4*W-1:0] a_d;
  logic           a_ov, a_oa;
  logic [W+1:0]   a_od;

  logic [3:0]     b_v, b_a;
  logic [4*W-1:0] b_d;
  logic           b_ov, b_oa;
  logic [W+1:0]   b_od;

  logic [2:0]     c_v, c_a;
  logic [3*W-1:0] c_d;
  logic           c_ov, c_oa;
  logic [W+1:0]   c_od;

  channel_merge_rr #(.NIN(4), .W(W), .TAG(1), .BURST(1)) u_a (
    .clk(clk), .reset(reset),
    .in_v(a_v), .in_a(a_a), .in_d(a_d),
    .out_v(a_ov), .out_a(a_oa), .out_d(a_od)
  );

  channel_merge_rr #(.NIN(4), .W(W), .TAG(1), .BURST(3)) u_b (
    .clk(clk), .reset(reset),
    .in_v(b_v), .in_a(b_a), .in_d(b_d),
    .out_v(b_ov), .out_a(b_oa), .out_d(b_od)
  );

  channel_merge_rr #(.NIN(3), .W(W), .TAG(1), .BURST(1)) u_c (
    .clk(clk), .reset(reset),
    .in_v(c_v), .in_a(c_a), .in_d(c_d),
    .out_v(c_ov), .out_a(c_oa), .out_d(c_od)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int seq3 [14] = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 2, 2, 2, 0, 2};

  logic [W+1:0] sbq [$];
  int           m_last, m_bcnt, sel, seq;
  logic         m_load;
  logic [3:0]   exp_a, took;

  initial begin
    reset = 1'b0;
    a_v = '0; a_oa = 1'b1;
    b_v = '0; b_oa = 1'b1;
    c_v = '0; c_oa = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_d[i*W +: W] = 32'hD000_0000 + i;
      b_d[i*W +: W] = 32'hB000_0000 + i;
    end
    for (int i = 0; i < 3; i++)
      c_d[i*W +: W] = 32'hC000_0000 + i;
    #1 reset = 1'b1;
    a_v = 4'b1111;
    #2;
    chk("rst_ov", a_ov, 0);
    chk("rst_ia", a_a, 0);
    chk("rst_od", a_od, 0);
    tick();
    tick();
    chk("rst_hold_ov", a_ov, 0);
    chk("rst_hold_ia", a_a, 0);
    reset = 1'b0;

    // round robin, all valid, output always ready
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ack", a_a, 4'b0001 << (k % 4));
      tick();
      chk("rr_v", a_ov, 1);
      chk("rr_d", a_od, {2'(k % 4), a_d[(k%4)*W +: W]});
    end

    // backpressure on a single source
    a_v = '0;
    tick();
    chk("drain_v", a_ov, 0);
    a_d[W +: W] = 32'hA5A5_0001;
    a_v = 4'b0010;
    a_oa = 1'b0;
    #1 chk("bp_load_ack", a_a, 4'b0010);
    tick();
    chk("bp_v", a_ov, 1);
    chk("bp_d", a_od, {2'd1, 32'hA5A5_0001});
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ack", a_a, 0);
      tick();
      chk("bp_hold_v", a_ov, 1);
      chk("bp_hold_d", a_od, {2'd1, 32'hA5A5_0001});
    end
    a_oa = 1'b1;
    #1 chk("bp_release_ack", a_a, 4'b0010);
    tick();
    chk("bp_nobubble", a_ov, 1);

    // async reset during a stall
    a_oa = 1'b0;
    tick();
    chk("stall_v", a_ov, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_v", a_ov, 0);
    chk("async_rst_ia", a_a, 0);
    chk("async_rst_d", a_od, 0);
    a_v = 4'b1010;
    a_oa = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("post_rst_ack", a_a, 4'b0010);
    tick();
    chk("post_rst_d", a_od, {2'd1, 32'hA5A5_0001});
    a_v = '0;
    tick();

    // burst lock, inputs 0 and 2
    b_v = 4'b0101;
    for (int k = 0; k < 14; k++) begin
      if (k == 13) b_v = 4'b0100;
      #1 chk("burst_ack", b_a, 4'b0001 << seq3[k]);
      tick();
      chk("burst_d", b_od, {2'(seq3[k]), b_d[seq3[k]*W +: W]});
    end
    b_v = '0;
    tick();

    // three inputs, sparse requests and wrap
    c_v = 3'b100;
    #1 chk("wrap_ack0", c_a, 3'b100);
    tick();
    chk("wrap_d0", c_od, {2'd2, c_d[2*W +: W]});
    c_v = 3'b110;
    #1 chk("wrap_ack1", c_a, 3'b010);
    tick();
    chk("wrap_d1", c_od, {2'd1, c_d[1*W +: W]});
    #1 chk("wrap_ack2", c_a, 3'b100);
    tick();
    c_v = '0;
    tick();

    // random valid/ready on the burst variant against the scoreboard
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_last = 3;
    m_bcnt = 0;
    took = '1;
    seq = 0;
    for (int c = 0; c < 10000; c++) begin
      chk("sb_v", b_ov, 64'(sbq.size() != 0));
      if (sbq.size() != 0) chk("sb_d", b_od, sbq[0]);
      b_oa = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (took[i]) begin
          b_d[i*W +: W] = {i[7:0], 8'h00, 16'(seq)};
          seq++;
        end
        b_v[i] = ($urandom_range(0, 2) != 0);
      end
      #1;
      sel = -1;
      if (b_v[m_last] && m_bcnt < 2) sel = m_last;
      else
        for (int k = 1; k <= 4; k++)
          if (sel < 0 && b_v[(m_last + k) % 4]) sel = (m_last + k) % 4;
      m_load = (sel >= 0) && (sbq.size() == 0 || b_oa);
      exp_a = m_load ? (4'b0001 << sel) : 4'b0000;
      chk("sb_ack", b_a, exp_a);
      took = '0;
      if (b_oa && sbq.size() != 0) void'(sbq.pop_front());
      if (m_load) begin
        sbq.push_back({2'(sel), b_d[sel*W +: W]});
        took[sel] = 1'b1;
        if (sel != m_last) m_bcnt = 0;
        else if (m_bcnt < 2) m_bcnt++;
        m_last = sel;
      end
      tick();
    end
    chk("sb_final_v", b_ov, 64'(sbq.size() != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
